nic_pe_port: RTL and testbench
==============================

Name: nic_pe_port

Overview:
- Network interface controller between a processing element (PE) and the router's local PE port. It is the opposite end of the router's pesi/pedi/peri and peso/pero/pedo handshakes.
- Injection side: holds one PE-written packet. Drives it to the router only in the polarity phase that matches the packet's virtual-channel bit, and only when the router is ready.
- Ejection side: accepts one packet from the router into a single-entry buffer. The PE drains it through a 2-bit register-mapped read/write interface.

Parameters:
- DATA_WIDTH, 64, packet and PE data width. Bit DATA_WIDTH-1 is the VC bit.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- addr  input  2  PE register select: 0 = input buffer, 1 = input status, 2 = output buffer, 3 = output status
- d_in  input  DATA_WIDTH  PE write data
- d_out  output  DATA_WIDTH  PE read data, registered
- nicEn  input  1  PE access enable
- nicWrEn  input  1  1 = write, 0 = read; qualified by nicEn
- net_so  output  1  send to router (drives router pesi)
- net_ro  input  1  router ready (router peri)
- net_do  output  DATA_WIDTH  packet to router (router pedi)
- net_si  input  1  router send (router peso)
- net_ri  output  1  NIC ready to accept (router pero)
- net_di  input  DATA_WIDTH  packet from router (router pedo)
- net_polarity  input  1  router polarity output; toggles every cycle after reset

Behaviour:
- Reset (sync, active-high) sets:
  - in_buf = 0, in_full = 0
  - out_buf = 0, out_full = 0
  - drop_flag = 0, d_out = 0
  - net_so = 0, net_ri = 1 (combinational from in_full = 0)
- Reset asserted mid-transfer discards both buffers; no partial state survives.
- Injection (output channel):
  - PE write: nicEn=1, nicWrEn=1, addr=2.
  - If out_full=0 at the edge: out_buf <= d_in, out_full <= 1.
  - If out_full=1: write dropped, buffer unchanged, drop_flag <= 1.
  - net_do = out_buf (continuous).
  - net_so = out_full & net_ro & (out_buf[DATA_WIDTH-1] == net_polarity); combinational.
  - When net_so=1 at an edge, out_full <= 0. Transfer completes in that single cycle; the router latches pedi on the same edge.
  - VC bit mismatched to net_polarity: packet waits at most 1 cycle for the matching phase (given net_ro=1).
  - net_ro=0: packet held indefinitely; no timeout.
- Same-edge PE write and net_so: out_full is 1 before the edge, so the write is dropped and drop_flag is set. The PE must poll status first.
- Ejection (input channel):
  - net_ri = ~in_full; combinational.
  - net_si=1 and in_full=0 at edge: in_buf <= net_di, in_full <= 1.
  - net_si=1 while in_full=1 is a protocol violation: ignored, in_buf unchanged.
  - PE read of addr=0 (nicEn=1, nicWrEn=0): d_out <= in_buf. If in_full=1, in_full <= 0 at the same edge.
  - Reading addr 0 when empty returns the stale in_buf and does not change state.
  - Same-edge PE read of addr 0 and net_si with in_full=1: net_ri was 0, so the new packet is not taken. in_full clears, and the router can send on the next cycle, where net_ri=1.
- Status reads (registered):
  - addr=1: d_out <= {zeros, in_full}
  - addr=3: d_out <= {zeros, drop_flag, out_full}; this read clears drop_flag at the same edge.
- Write/read to other addresses:
  - Writes to addr 0, 1, 3: ignored.
  - Read of addr 2: returns out_buf, no side effect.
- Read timing: d_out is valid 1 cycle after the read request.
- nicEn=0, or any write cycle: d_out <= 0.

Test Plan:
- Reset then idle:
  - Expect net_so=0, net_ri=1, d_out=0.
  - Status read addr=3 gives 0 next cycle.
- Injection with VC check:
  - Write addr=2 d_in=64'h8000_0000_0000_00A5, net_ro=1.
  - net_so rises only in the cycle net_polarity=1; net_do=8000...00A5.
  - out_full=0 on the following cycle.
- Backpressure:
  - Hold net_ro=0 for 10 cycles after the write; net_so stays 0.
  - Raise net_ro; net_so pulses for exactly 1 cycle in the matching phase.
- Drop:
  - Write addr=2 twice on consecutive cycles with net_ro=0.
  - Status read returns 2'b11, and a second status read returns 2'b01.
  - out_buf holds the first value.
- Ejection:
  - net_si=1, net_di=64'h0000_1234_5678_9ABC.
  - Next cycle net_ri=0; read addr=1 returns 1.
  - Read addr=0 returns ...9ABC; the cycle after, net_ri=1.
- Overlap:
  - in_full=1, router holds net_si=1, PE reads addr=0 in the same cycle.
  - The old packet is returned and the new packet is latched on the next edge.
  - Then reset asserted mid-hold: all flags 0 and net_ri=1 after the edge.

Source files
------------

// File: rtl/nic_pe_port_if.sv
// PE register bus plus router local-port handshakes for the NIC.
// slave = NIC view; master = the PE/router side driving it.
interface nic_pe_port_if #(
   parameter int DATA_WIDTH = 64
);
   logic [1:0]            addr;
   logic [DATA_WIDTH-1:0] d_in;
   logic [DATA_WIDTH-1:0] d_out;
   logic                  nicEn;
   logic                  nicWrEn;
   logic                  net_so;
   logic                  net_ro;
   logic [DATA_WIDTH-1:0] net_do;
   logic                  net_si;
   logic                  net_ri;
   logic [DATA_WIDTH-1:0] net_di;
   logic                  net_polarity;

   modport slave (
      input  addr, d_in, nicEn, nicWrEn, net_ro, net_si, net_di, net_polarity,
      output d_out, net_so, net_do, net_ri
   );

   modport master (
      output addr, d_in, nicEn, nicWrEn, net_ro, net_si, net_di, net_polarity,
      input  d_out, net_so, net_do, net_ri
   );
endinterface

// File: rtl/nic_pe_port.sv
// NIC between a PE and the router local port; one-entry inject/eject buffers, d_out 1 cycle after a read.
// Inject waits on net_ro and VC/polarity match; eject is held off by net_ri until the PE reads addr 0.
module nic_pe_port #(
   parameter int DATA_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   nic_pe_port_if.slave         bus
);
   logic [DATA_WIDTH-1:0] in_buf_q,  in_buf_d;
   logic                  in_full_q, in_full_d;
   logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
   logic                  out_full_q, out_full_d;
   logic                  drop_q,    drop_d;
   logic [DATA_WIDTH-1:0] d_out_q,   d_out_d;

   logic pe_wr;
   logic pe_rd;
   logic net_so;

   assign pe_wr  = bus.nicEn & bus.nicWrEn;
   assign pe_rd  = bus.nicEn & ~bus.nicWrEn;
   // A packet may only leave in the router phase that matches its VC bit.
   assign net_so = out_full_q & bus.net_ro & (out_buf_q[DATA_WIDTH-1] == bus.net_polarity);

   assign bus.net_so = net_so;
   assign bus.net_do = out_buf_q;
   assign bus.net_ri = ~in_full_q;
   assign bus.d_out  = d_out_q;

   always_comb begin
      in_buf_d   = in_buf_q;
      in_full_d  = in_full_q;
      out_buf_d  = out_buf_q;
      out_full_d = out_full_q;
      drop_d     = drop_q;
      d_out_d    = '0;

      if (net_so)
         out_full_d = 1'b0;

      // A write landing on the same edge as a send still sees a full buffer and is dropped.
      if (pe_wr && bus.addr == 2'd2) begin
         if (out_full_q) begin
            drop_d = 1'b1;
         end else begin
            out_buf_d  = bus.d_in;
            out_full_d = 1'b1;
         end
      end

      if (bus.net_si && !in_full_q) begin
         in_buf_d  = bus.net_di;
         in_full_d = 1'b1;
      end

      if (pe_rd) begin
         case (bus.addr)
            2'd0: begin
               d_out_d = in_buf_q;
               if (in_full_q)
                  in_full_d = 1'b0;
            end
            2'd1: d_out_d = {{(DATA_WIDTH-1){1'b0}}, in_full_q};
            2'd2: d_out_d = out_buf_q;
            default: begin
               d_out_d = {{(DATA_WIDTH-2){1'b0}}, drop_q, out_full_q};
               drop_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_buf_q   <= '0;
         in_full_q  <= 1'b0;
         out_buf_q  <= '0;
         out_full_q <= 1'b0;
         drop_q     <= 1'b0;
         d_out_q    <= '0;
      end else begin
         in_buf_q   <= in_buf_d;
         in_full_q  <= in_full_d;
         out_buf_q  <= out_buf_d;
         out_full_q <= out_full_d;
         drop_q     <= drop_d;
         d_out_q    <= d_out_d;
      end
   end
endmodule

// File: tb/tb_nic_pe_port.sv
// Directed bench for nic_pe_port: reset, VC-gated injection, backpressure, drop, ejection, overlap, reset.
module tb_nic_pe_port;
   localparam int DW = 64;

   logic clk;
   logic reset;
   logic pol;
   int   checks;
   int   errors;

   nic_pe_port_if #(.DATA_WIDTH(DW)) bus ();

   nic_pe_port #(.DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Router polarity model: cleared by reset, toggles every cycle afterwards.
   always @(posedge clk) begin
      if (reset) pol <= 1'b0;
      else       pol <= ~pol;
   end
   assign bus.net_polarity = pol;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic pe_read(input logic [1:0] a);
      bus.nicEn   = 1'b1;
      bus.nicWrEn = 1'b0;
      bus.addr    = a;
      tick();
      bus.nicEn   = 1'b0;
   endtask

   task automatic pe_write(input logic [1:0] a, input logic [DW-1:0] d);
      bus.nicEn   = 1'b1;
      bus.nicWrEn = 1'b1;
      bus.addr    = a;
      bus.d_in    = d;
      tick();
      bus.nicEn   = 1'b0;
      bus.nicWrEn = 1'b0;
   endtask

   initial begin
      logic sent;
      int   pulses;
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.addr = 2'd0;  bus.d_in = '0;  bus.nicEn = 1'b0;  bus.nicWrEn = 1'b0;
      bus.net_ro = 1'b0; bus.net_si = 1'b0; bus.net_di = '0;
      tick();
      tick();
      reset = 1'b0;

      // Reset then idle
      check("rst_so", {63'd0, bus.net_so}, 64'd0);
      check("rst_ri", {63'd0, bus.net_ri}, 64'd1);
      check("rst_dout", bus.d_out, 64'd0);
      pe_read(2'd3);
      check("rst_status3", bus.d_out, 64'd0);

      // Injection of a VC1 packet: net_so only while polarity is 1
      bus.net_ro = 1'b1;
      pe_write(2'd2, 64'h8000_0000_0000_00A5);
      sent = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!sent) begin
            check("inj_so_phase", {63'd0, bus.net_so}, {63'd0, pol});
            if (pol) begin
               check("inj_do", bus.net_do, 64'h8000_0000_0000_00A5);
               sent = 1'b1;
            end
         end
         tick();
      end
      check("inj_sent", {63'd0, sent}, 64'd1);
      pe_read(2'd3);
      check("inj_status_empty", bus.d_out, 64'd0);

      // Backpressure: held while net_ro=0, then exactly one pulse
      bus.net_ro = 1'b0;
      pe_write(2'd2, 64'h8000_0000_0000_00B6);
      for (int i = 0; i < 10; i++) begin
         check("bp_so_low", {63'd0, bus.net_so}, 64'd0);
         tick();
      end
      bus.net_ro = 1'b1;
      #1;
      sent   = 1'b0;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
         check("bp_so", {63'd0, bus.net_so}, {63'd0, pol & ~sent});
         if (bus.net_so) begin
            pulses++;
            sent = 1'b1;
         end
         tick();
      end
      check("bp_pulses", 64'(pulses), 64'd1);

      // Drop: second write while full is lost and flagged
      bus.net_ro = 1'b0;
      pe_write(2'd2, 64'h0000_0000_0000_0011);
      pe_write(2'd2, 64'h0000_0000_0000_0022);
      pe_read(2'd3);
      check("drop_status1", bus.d_out, 64'd3);
      pe_read(2'd3);
      check("drop_status2", bus.d_out, 64'd1);
      pe_read(2'd2);
      check("drop_outbuf", bus.d_out, 64'h0000_0000_0000_0011);
      check("idle_dout", bus.d_out, 64'h0000_0000_0000_0011);
      tick();
      check("idle_dout_zero", bus.d_out, 64'd0);
      bus.net_ro = 1'b1;
      tick();
      tick();
      tick();
      pe_read(2'd3);
      check("drop_drained", bus.d_out, 64'd0);

      // Writes to non-buffer addresses are ignored
      pe_write(2'd3, 64'hFFFF_FFFF_FFFF_FFFF);
      check("wr_dout_zero", bus.d_out, 64'd0);
      pe_read(2'd3);
      check("wr3_ignored", bus.d_out, 64'd0);

      // Ejection
      bus.net_si = 1'b1;
      bus.net_di = 64'h0000_1234_5678_9ABC;
      tick();
      bus.net_si = 1'b0;
      check("ej_ri_low", {63'd0, bus.net_ri}, 64'd0);
      pe_read(2'd1);
      check("ej_status", bus.d_out, 64'd1);
      pe_read(2'd0);
      check("ej_data", bus.d_out, 64'h0000_1234_5678_9ABC);
      check("ej_ri_high", {63'd0, bus.net_ri}, 64'd1);
      pe_read(2'd0);
      check("ej_stale", bus.d_out, 64'h0000_1234_5678_9ABC);
      pe_read(2'd1);
      check("ej_status_empty", bus.d_out, 64'd0);

      // Overlap: read and held net_si on the same edge
      bus.net_si = 1'b1;
      bus.net_di = 64'h0000_0000_0000_1111;
      tick();
      bus.net_di = 64'h0000_0000_0000_2222;
      pe_read(2'd0);
      check("ov_old", bus.d_out, 64'h0000_0000_0000_1111);
      check("ov_ri", {63'd0, bus.net_ri}, 64'd1);
      tick();
      check("ov_ri_full", {63'd0, bus.net_ri}, 64'd0);
      bus.net_si = 1'b0;
      pe_read(2'd0);
      check("ov_new", bus.d_out, 64'h0000_0000_0000_2222);

      // Reset mid-hold discards both buffers
      bus.net_si = 1'b1;
      bus.net_di = 64'h0000_0000_0000_3333;
      bus.net_ro = 1'b0;
      pe_write(2'd2, 64'h0000_0000_0000_0044);
      pe_write(2'd2, 64'h0000_0000_0000_0055);
      reset      = 1'b1;
      bus.net_si = 1'b0;
      tick();
      reset      = 1'b0;
      bus.net_ro = 1'b1;
      #1;
      check("mr_ri", {63'd0, bus.net_ri}, 64'd1);
      check("mr_so", {63'd0, bus.net_so}, 64'd0);
      check("mr_dout", bus.d_out, 64'd0);
      pe_read(2'd1);
      check("mr_status1", bus.d_out, 64'd0);
      pe_read(2'd3);
      check("mr_status3", bus.d_out, 64'd0);
      pe_read(2'd2);
      check("mr_outbuf", bus.d_out, 64'd0);
      pe_read(2'd0);
      check("mr_inbuf", bus.d_out, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
